// File: rtl/reg_writeback_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_writeback_arbiter_pkg
//  Description : Shared types and constants for the integer register-file
//                write-back arbiter. Holds the register-file geometry, the
//                buffered write request record, the arbiter FSM encoding and
//                a one-hot helper used when building the pending-write mask.
//  Revision    : 1.0  - initial release
// ============================================================================
package reg_writeback_arbiter_pkg;

    // Register file geometry: 32 architectural registers, 32-bit datapath.
    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    // One buffered write to the register file.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] waddr;
        logic [XLEN-1:0]       wdata;
    } wb_req_t;

    // Arbiter states. NORMAL lets the ALU win; DRAIN is a single forced
    // cycle in which the load/store buffer owns the write port.
    typedef enum logic [0:0] {
        WB_NORMAL = 1'b0,
        WB_DRAIN  = 1'b1
    } wb_state_e;

    // One-hot decode of a register address. x0 is hard-wired to zero and
    // never counts as a pending destination, so its bit is always cleared.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] v;
        v       = '0;
        v[addr] = 1'b1;
        v[0]    = 1'b0;
        return v;
    endfunction

endpackage : reg_writeback_arbiter_pkg
`default_nettype wire

// File: rtl/reg_writeback_arbiter_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_fifo
//  Description : Synchronous circular FIFO for long-latency load/store write
//                requests. Power-of-two depth, so read/write pointers wrap
//                naturally. Exports each slot's destination address and a
//                per-slot occupancy flag so the parent can build a
//                pending-write mask without walking the queue.
//  Ports       : clk_i          - clock, rising edge
//                rst_i          - asynchronous reset, active low
//                push_i         - enqueue request (ignored when full)
//                push_waddr_i   - destination register of pushed entry
//                push_wdata_i   - data of pushed entry
//                pop_i          - dequeue head (ignored when empty)
//                head_waddr_o   - destination register at the head
//                head_wdata_o   - data at the head
//                count_o        - number of occupied slots (0..DEPTH)
//                entry_addr_o   - flattened per-slot destination addresses
//                entry_valid_o  - per-slot occupancy flags
//  Revision    : 1.0  - initial release
// ============================================================================
module wb_fifo
    import reg_writeback_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  push_i,
    input  logic [REG_ADDR_W-1:0]                 push_waddr_i,
    input  logic [XLEN-1:0]                       push_wdata_i,
    input  logic                                  pop_i,
    output logic [REG_ADDR_W-1:0]                 head_waddr_o,
    output logic [XLEN-1:0]                       head_wdata_o,
    output logic [$clog2(DEPTH):0]                count_o,
    output logic [DEPTH*REG_ADDR_W-1:0]           entry_addr_o,
    output logic [DEPTH-1:0]                      entry_valid_o
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    wb_req_t              r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;

    logic                 w_do_push;
    logic                 w_do_pop;

    // Protect internal state against an out-of-contract push or pop.
    assign w_do_push = push_i && (r_count != c_FULL);
    assign w_do_pop  = pop_i  && (r_count != '0);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= '{waddr: push_waddr_i, wdata: push_wdata_i};
                r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign head_waddr_o = r_mem[r_rd_ptr].waddr;
    assign head_wdata_o = r_mem[r_rd_ptr].wdata;
    assign count_o      = r_count;

    // A slot is occupied when its distance from the read pointer (modulo
    // DEPTH, which the pointer width provides for free) is below count.
    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_entry
            logic [c_PTR_W-1:0] w_offset;
            assign w_offset         = c_PTR_W'(g) - r_rd_ptr;
            assign entry_valid_o[g] = ({1'b0, w_offset} < r_count);
            assign entry_addr_o[g*REG_ADDR_W +: REG_ADDR_W] = r_mem[g].waddr;
        end
    endgenerate

endmodule : wb_fifo
`default_nettype wire

// File: rtl/reg_writeback_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : reg_writeback_arbiter
//  Description : Writer side of the 2R/1W integer register file. Arbitrates
//                the single write port between the single-cycle ALU result
//                path and the buffered load/store result path. The ALU wins
//                by default; after STARVE_MAX consecutive ALU wins with the
//                buffer occupied, one cycle is forced to drain the buffer.
//                Writes to x0 are accepted and dropped.
//  Ports       : clk_i          - clock, rising edge
//                rst_i          - asynchronous reset, active low
//                alu_valid_i    - ALU result valid
//                alu_ready_o    - ALU result accepted this cycle
//                alu_waddr_i    - ALU destination register
//                alu_wdata_i    - ALU result
//                lsu_valid_i    - LSU result valid
//                lsu_ready_o    - buffer can accept an LSU result
//                lsu_waddr_i    - LSU destination register
//                lsu_wdata_i    - LSU result
//                wen_o          - register-file write enable (registered)
//                waddr_o        - register-file write address (registered)
//                wdata_o        - register-file write data (registered)
//                pending_mask_o - bit i set while a write to x i is buffered
//                                 or sitting in the output stage
//  Revision    : 1.0  - initial release
// ============================================================================
module reg_writeback_arbiter
    import reg_writeback_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        alu_valid_i,
    output logic        alu_ready_o,
    input  logic [4:0]  alu_waddr_i,
    input  logic [31:0] alu_wdata_i,
    input  logic        lsu_valid_i,
    output logic        lsu_ready_o,
    input  logic [4:0]  lsu_waddr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        wen_o,
    output logic [4:0]  waddr_o,
    output logic [31:0] wdata_o,
    output logic [31:0] pending_mask_o
);

    localparam int c_CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int c_STARVE_W = $clog2(STARVE_MAX + 1);
    localparam logic [c_CNT_W-1:0]    c_FIFO_FULL  = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_MAX);

    // ------------------------------------------------------------------------
    // Internal signals
    // ------------------------------------------------------------------------
    wb_state_e                          r_state;
    wb_state_e                          w_state_nxt;
    logic [c_STARVE_W-1:0]              r_starve_cnt;
    logic [c_STARVE_W-1:0]              w_starve_inc;

    logic                               r_wen;
    logic [REG_ADDR_W-1:0]              r_waddr;
    logic [XLEN-1:0]                    r_wdata;

    logic                               w_alu_ready;
    logic                               w_alu_req;
    logic                               w_alu_win;
    logic                               w_lsu_ready;
    logic                               w_lsu_push;
    logic                               w_pop;

    logic [REG_ADDR_W-1:0]              w_head_waddr;
    logic [XLEN-1:0]                    w_head_wdata;
    logic [c_CNT_W-1:0]                 w_count;
    logic                               w_fifo_empty;
    logic [FIFO_DEPTH*REG_ADDR_W-1:0]   w_entry_addr;
    logic [FIFO_DEPTH-1:0]              w_entry_valid;
    logic [NUM_REGS-1:0]                w_mask;

    // ------------------------------------------------------------------------
    // LSU result buffer
    // ------------------------------------------------------------------------
    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_wb_fifo (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .push_i        (w_lsu_push),
        .push_waddr_i  (lsu_waddr_i),
        .push_wdata_i  (lsu_wdata_i),
        .pop_i         (w_pop),
        .head_waddr_o  (w_head_waddr),
        .head_wdata_o  (w_head_wdata),
        .count_o       (w_count),
        .entry_addr_o  (w_entry_addr),
        .entry_valid_o (w_entry_valid)
    );

    assign w_fifo_empty = (w_count == '0);

    // Ready depends on occupancy alone; a pop in the same cycle does not
    // free a slot until the next cycle. Keeps the path short.
    assign w_lsu_ready  = (w_count != c_FIFO_FULL);

    // x0 results are handshaken but never buffered.
    assign w_lsu_push   = lsu_valid_i && w_lsu_ready && (lsu_waddr_i != '0);

    // An ALU result only competes for the port if it actually writes.
    assign w_alu_req    = alu_valid_i && (alu_waddr_i != '0);

    assign w_starve_inc = r_starve_cnt + c_STARVE_W'(1);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= WB_NORMAL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WB_NORMAL: begin
                // The win that brings the starvation count to its limit
                // schedules the forced drain for the following cycle. The
                // buffer cannot empty in between because the ALU owned
                // the port this cycle.
                if (w_alu_win && !w_fifo_empty && (w_starve_inc == c_STARVE_MAX)) begin
                    w_state_nxt = WB_DRAIN;
                end
            end
            WB_DRAIN: begin
                w_state_nxt = WB_NORMAL;
            end
            default: begin
                w_state_nxt = WB_NORMAL;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_alu_ready = 1'b1;
        w_alu_win   = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            WB_NORMAL: begin
                w_alu_ready = 1'b1;
                w_alu_win   = w_alu_req;
                w_pop       = !w_alu_req && !w_fifo_empty;
            end
            WB_DRAIN: begin
                w_alu_ready = 1'b0;
                w_alu_win   = 1'b0;
                w_pop       = !w_fifo_empty;
            end
            default: begin
                w_alu_ready = 1'b1;
                w_alu_win   = 1'b0;
                w_pop       = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Starvation counter: counts ALU wins taken while the buffer waits.
    // Any buffer pop, an empty buffer or the drain cycle restart it.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_starve_cnt <= '0;
        end else if ((r_state == WB_DRAIN) || w_fifo_empty || !w_alu_win) begin
            r_starve_cnt <= '0;
        end else begin
            r_starve_cnt <= w_starve_inc;
        end
    end

    // ------------------------------------------------------------------------
    // Registered write port. Address/data hold their last values when no
    // source wins so the register file sees no needless toggling.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_wen <= w_alu_win || w_pop;
            if (w_alu_win) begin
                r_waddr <= alu_waddr_i;
                r_wdata <= alu_wdata_i;
            end else if (w_pop) begin
                r_waddr <= w_head_waddr;
                r_wdata <= w_head_wdata;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Pending-write mask: every buffered destination plus the write in
    // flight. Duplicates simply OR together.
    // ------------------------------------------------------------------------
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (w_entry_valid[i]) begin
                w_mask = w_mask | reg_onehot(w_entry_addr[i*REG_ADDR_W +: REG_ADDR_W]);
            end
        end
        if (r_wen) begin
            w_mask = w_mask | reg_onehot(r_waddr);
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign alu_ready_o    = w_alu_ready;
    assign lsu_ready_o    = w_lsu_ready;
    assign wen_o          = r_wen;
    assign waddr_o        = r_waddr;
    assign wdata_o        = r_wdata;
    assign pending_mask_o = w_mask;

endmodule : reg_writeback_arbiter
`default_nettype wire
